// File: rtl/falafel_pkg.sv
// Shared types for the falafel allocator: LSU request/response records,
// LSU op codes, the LSU arbiter state encoding and a port-index width helper.
package falafel_pkg;

    localparam int HDR_DATA_W = 32;

    typedef enum logic [2:0] {
        LOCK   = 3'd0,
        UNLOCK = 3'd1,
        LOAD   = 3'd2,
        INSERT = 3'd3,
        DELETE = 3'd4
    } req_lsu_op_e;

    typedef struct packed {
        logic                  val;
        req_lsu_op_e           lsu_op;
        logic [HDR_DATA_W-1:0] header_data;
    } header_data_req_t;

    typedef struct packed {
        logic                  val;
        logic [HDR_DATA_W-1:0] header_data;
    } header_data_rsp_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWNED,
        ARB_WAIT_RSP
    } arb_state_e;

    // Width of a port index; never narrower than one bit.
    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/falafel_rr_picker.sv
// Combinational round-robin picker: selects the first asserted request at or
// after ptr_i, wrapping modulo N. Returns one-hot grant, index and any-valid.
module falafel_rr_picker
    import falafel_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = port_w(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_valid_o
);

    logic [IDX_W-1:0] cand;

    // Scan ports in priority order starting at the pointer; first hit wins.
    always_comb begin
        grant_o     = '0;
        idx_o       = '0;
        any_valid_o = 1'b0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % N);
            if (!any_valid_o && req_i[cand]) begin
                any_valid_o   = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/falafel_lsu_arbiter.sv
// Shares one falafel LSU between NUM_PORTS cores. A core wins ownership with a
// LOCK and keeps it until its UNLOCK has been answered; request and response
// pass straight through with no added latency. Lock grants rotate round-robin.
// Optional build macro FALAFEL_ARB_STATS_EN adds saturating per-port counters
// of accepted LOCK requests on grant_cnt_o.
module falafel_lsu_arbiter
    import falafel_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  header_data_req_t [NUM_PORTS-1:0]     core_req_i,
    output logic [NUM_PORTS-1:0]                 core_lsu_ready_o,
    output header_data_rsp_t [NUM_PORTS-1:0]     core_rsp_o,
    output header_data_req_t                     lsu_req_o,
    input  logic                                 lsu_ready_i,
    input  header_data_rsp_t                     lsu_rsp_i,
    output logic [port_w(NUM_PORTS)-1:0]         owner_o,
    output logic                                 busy_o
`ifdef FALAFEL_ARB_STATS_EN
    ,
    output logic [NUM_PORTS-1:0][CNT_W-1:0]      grant_cnt_o
`endif
);

    localparam int                PORT_W    = port_w(NUM_PORTS);
    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

    arb_state_e        state_q, state_d;
    logic [PORT_W-1:0] owner_q, owner_d;
    logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
    req_lsu_op_e       op_q, op_d;

    logic [NUM_PORTS-1:0] lock_req;
    logic [NUM_PORTS-1:0] win_grant;
    logic [PORT_W-1:0]    win_idx;
    logic                 win_valid;

    header_data_req_t                 req_c;
    logic [NUM_PORTS-1:0]             ready_c;
    header_data_rsp_t [NUM_PORTS-1:0] rsp_c;
    logic                             busy_c;
    logic [PORT_W-1:0]                owner_c;
    logic [PORT_W-1:0]                sel_idx;
    logic                             fwd;
    logic                             accept;

    // Only LOCK requests compete for ownership; anything else from a non-owner is ignored.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_lock_req
        assign lock_req[gi] = core_req_i[gi].val && (core_req_i[gi].lsu_op == LOCK);
    end

    falafel_rr_picker #(
        .N     (NUM_PORTS),
        .IDX_W (PORT_W)
    ) u_picker (
        .req_i       (lock_req),
        .ptr_i       (rr_ptr_q),
        .grant_o     (win_grant),
        .idx_o       (win_idx),
        .any_valid_o (win_valid)
    );

    // Next-state and pass-through routing; the forwarded port is the lock
    // winner when idle and the owner while owned. Nothing is forwarded while
    // a response is outstanding, so a same-cycle owner request waits.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        op_d     = op_q;
        req_c    = '0;
        ready_c  = '0;
        rsp_c    = '0;
        busy_c   = 1'b0;
        owner_c  = '0;
        sel_idx  = '0;
        fwd      = 1'b0;
        accept   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    sel_idx = win_idx;
                    fwd     = 1'b1;
                    ready_c = win_grant & {NUM_PORTS{lsu_ready_i}};
                end
            end
            ARB_OWNED: begin
                busy_c           = 1'b1;
                owner_c          = owner_q;
                sel_idx          = owner_q;
                fwd              = 1'b1;
                ready_c[owner_q] = lsu_ready_i;
            end
            ARB_WAIT_RSP: begin
                busy_c         = 1'b1;
                owner_c        = owner_q;
                rsp_c[owner_q] = lsu_rsp_i;
                if (lsu_rsp_i.val) begin
                    if (op_q == UNLOCK) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = (owner_q == LAST_PORT) ? '0 : owner_q + PORT_W'(1);
                    end else begin
                        state_d = ARB_OWNED;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (fwd) begin
            req_c = core_req_i[sel_idx];
        end
        accept = req_c.val && lsu_ready_i;
        if (accept) begin
            op_d    = req_c.lsu_op;
            owner_d = sel_idx;
            state_d = ARB_WAIT_RSP;
        end
    end

    // Outputs are held at zero for as long as reset is asserted.
    assign lsu_req_o        = rst_i ? '0   : req_c;
    assign core_lsu_ready_o = rst_i ? '0   : ready_c;
    assign core_rsp_o       = rst_i ? '0   : rsp_c;
    assign busy_o           = rst_i ? 1'b0 : busy_c;
    assign owner_o          = rst_i ? '0   : owner_c;

    // Arbiter state registers; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            op_q     <= UNLOCK;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            op_q     <= op_d;
        end
    end

`ifdef FALAFEL_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Count accepted LOCKs from this port, sticking at all-ones.
        always_comb begin
            cnt_d = cnt_q;
            if (accept && (req_c.lsu_op == LOCK) && (sel_idx == PORT_W'(gi)) && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Counter register.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign grant_cnt_o[gi] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_falafel_lsu_arbiter.sv
// Bench for falafel_lsu_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// transaction-level model of lock ownership.
module tb_falafel_lsu_arbiter;
    import falafel_pkg::*;

    localparam int N  = 4;
    localparam int PW = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    header_data_req_t [N-1:0] core_req;
    logic [N-1:0]             core_rdy;
    header_data_rsp_t [N-1:0] core_rsp;
    header_data_req_t         lsu_req;
    logic                     lsu_ready;
    header_data_rsp_t         lsu_rsp;
    logic [PW-1:0]            owner;
    logic                     busy;
`ifdef FALAFEL_ARB_STATS_EN
    logic [N-1:0][15:0]       grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    falafel_lsu_arbiter #(.NUM_PORTS(N), .CNT_W(16)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .core_req_i       (core_req),
        .core_lsu_ready_o (core_rdy),
        .core_rsp_o       (core_rsp),
        .lsu_req_o        (lsu_req),
        .lsu_ready_i      (lsu_ready),
        .lsu_rsp_i        (lsu_rsp),
        .owner_o          (owner),
        .busy_o           (busy)
`ifdef FALAFEL_ARB_STATS_EN
        ,
        .grant_cnt_o      (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner = -1 means nobody holds the lock; waiting = a request of the
    // owner is in flight; last_op = op of that request; start = first port
    // considered at the next lock arbitration.
    int                       m_owner = -1;
    bit                       m_wait  = 0;
    req_lsu_op_e              m_op    = UNLOCK;
    int                       m_start = 0;
    int                       m_win;
    int                       m_p;
    int                       grant_log[$];
    header_data_req_t         e_req;
    logic [N-1:0]             e_rdy;
    header_data_rsp_t [N-1:0] e_rsp;
    logic                     e_busy;
    logic [PW-1:0]            e_own;

    always @(negedge clk) begin
        e_req  = '0;
        e_rdy  = '0;
        e_rsp  = '0;
        e_busy = 1'b0;
        e_own  = '0;
        if (rst) begin
            m_owner = -1;
            m_wait  = 0;
            m_op    = UNLOCK;
            m_start = 0;
        end else if (m_owner < 0) begin
            m_win = -1;
            for (int k = 0; k < N; k++) begin
                m_p = (m_start + k) % N;
                if (m_win < 0 && core_req[m_p].val && core_req[m_p].lsu_op == LOCK) m_win = m_p;
            end
            if (m_win >= 0) begin
                e_req        = core_req[m_win];
                e_rdy[m_win] = lsu_ready;
                if (lsu_ready) begin
                    m_owner = m_win;
                    m_wait  = 1;
                    m_op    = LOCK;
                    grant_log.push_back(m_win);
                end
            end
        end else if (m_wait) begin
            e_busy         = 1'b1;
            e_own          = PW'(m_owner);
            e_rsp[m_owner] = lsu_rsp;
            if (lsu_rsp.val) begin
                m_wait = 0;
                if (m_op == UNLOCK) begin
                    m_start = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end else begin
            e_busy         = 1'b1;
            e_own          = PW'(m_owner);
            e_req          = core_req[m_owner];
            e_rdy[m_owner] = lsu_ready;
            if (core_req[m_owner].val && lsu_ready) begin
                m_op   = core_req[m_owner].lsu_op;
                m_wait = 1;
            end
        end
        chk("model_lsu_req", lsu_req, e_req);
        chk("model_ready", core_rdy, e_rdy);
        chk("model_rsp", core_rsp, e_rsp);
        chk("model_busy", busy, e_busy);
        chk("model_owner", owner, e_own);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        core_req  = '0;
        lsu_ready = 1'b0;
        lsu_rsp   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    // Port p wins the lock from idle; its LOCK is answered; ends owned.
    task automatic lock_grant(input int p);
        logic [N-1:0] oh;
        oh              = '0;
        oh[p]           = 1'b1;
        core_req[p]     = '{val: 1'b1, lsu_op: LOCK, header_data: 32'hC0DE_0000 + 32'(p)};
        lsu_ready       = 1'b1;
        #1;
        chk($sformatf("grant_ready_p%0d", p), core_rdy, oh);
        step();
        core_req[p].val = 1'b0;
        lsu_rsp         = '{val: 1'b1, header_data: $urandom};
        #1;
        chk($sformatf("owner_is_p%0d", p), owner, p);
        step();
        lsu_rsp = '0;
    endtask

    // Owner p issues op, it is accepted and answered.
    task automatic owner_txn(input int p, input req_lsu_op_e op);
        logic [N-1:0]             oh;
        header_data_rsp_t [N-1:0] ev;
        oh          = '0;
        oh[p]       = 1'b1;
        core_req[p] = '{val: 1'b1, lsu_op: op, header_data: $urandom};
        lsu_ready   = 1'b1;
        #1;
        chk($sformatf("owner_ready_p%0d", p), core_rdy, oh);
        step();
        core_req[p].val = 1'b0;
        lsu_rsp         = '{val: 1'b1, header_data: $urandom};
        #1;
        ev    = '0;
        ev[p] = lsu_rsp;
        chk($sformatf("rsp_only_p%0d", p), core_rsp, ev);
        step();
        lsu_rsp = '0;
    endtask

    int base;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        clear_inputs();
        // Reset state, with a LOCK present that must not leak out.
        core_req[1] = '{val: 1'b1, lsu_op: LOCK, header_data: 32'h1};
        lsu_ready   = 1'b1;
        #2;
        chk("rst_lsu_req", lsu_req, 36'h0);
        chk("rst_ready", core_rdy, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 0);
        chk("rst_rsp", core_rsp, 132'h0);
        do_reset();

        // Single lock from port 2.
        core_req[2] = '{val: 1'b1, lsu_op: LOCK, header_data: 32'hA2};
        lsu_ready   = 1'b1;
        #1;
        chk("single_req_val", lsu_req.val, 1'b1);
        lock_grant(2);
        chk("single_busy", busy, 1'b1);
        owner_txn(2, UNLOCK);
        chk("single_idle_after_unlock", busy, 1'b0);

        // Stray response in idle and a lockless INSERT.
        lsu_rsp     = '{val: 1'b1, header_data: 32'hDEAD};
        core_req[1] = '{val: 1'b1, lsu_op: INSERT, header_data: 32'h55};
        #1;
        chk("stray_rsp_dropped", core_rsp, 132'h0);
        chk("insert_no_ready", core_rdy, 4'h0);
        chk("insert_not_fwd", lsu_req.val, 1'b0);
        step();
        clear_inputs();

        // Contention between ports 0 and 3.
        do_reset();
        core_req[3] = '{val: 1'b1, lsu_op: LOCK, header_data: 32'h3};
        core_req[0] = '{val: 1'b1, lsu_op: LOCK, header_data: 32'h0};
        lock_grant(0);
        owner_txn(0, LOAD);
        owner_txn(0, DELETE);
        owner_txn(0, UNLOCK);
        lock_grant(3);
        owner_txn(3, UNLOCK);

        // Fairness with every port holding LOCK.
        do_reset();
        base = grant_log.size();
        for (int i = 0; i < 5; i++) begin
            for (int p = 0; p < N; p++) core_req[p] = '{val: 1'b1, lsu_op: LOCK, header_data: 32'(p)};
            lock_grant(exp_order[i]);
            owner_txn(exp_order[i], UNLOCK);
        end
        for (int i = 0; i < 5; i++) begin
            if (base + i < grant_log.size()) chk($sformatf("fair_order_%0d", i), grant_log[base + i], exp_order[i]);
            else chk($sformatf("fair_order_%0d_missing", i), 1'b0, 1'b1);
        end
        clear_inputs();

        // Backpressure on an owner LOAD.
        do_reset();
        lock_grant(1);
        core_req[1] = '{val: 1'b1, lsu_op: LOAD, header_data: 32'hB1};
        lsu_ready   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_req_held", lsu_req.val, 1'b1);
            chk("bp_ready_low", core_rdy, 4'h0);
            step();
        end
        lsu_ready = 1'b1;
        #1;
        chk("bp_ready_high", core_rdy, 4'b0010);
        step();
        lsu_rsp = '{val: 1'b1, header_data: 32'h77};
        #1;
        chk("bp_req_blocked_in_rsp_cycle", lsu_req.val, 1'b0);
        chk("bp_rsp_routed", core_rsp[1].val, 1'b1);
        step();
        lsu_rsp = '0;
        #1;
        chk("bp_next_req_fwd", lsu_req.val, 1'b1);
        step();
        core_req[1].val = 1'b0;
        lsu_rsp         = '{val: 1'b1, header_data: 32'h78};
        step();
        lsu_rsp = '0;
        owner_txn(1, UNLOCK);

        // Async reset while a response is outstanding.
        do_reset();
        lock_grant(2);
        owner_txn(2, UNLOCK);
        lock_grant(2);
        core_req[2] = '{val: 1'b1, lsu_op: LOAD, header_data: 32'hE2};
        lsu_ready   = 1'b1;
        step();
        core_req    = '0;
        core_req[1] = '{val: 1'b1, lsu_op: LOCK, header_data: 32'h11};
        core_req[3] = '{val: 1'b1, lsu_op: LOCK, header_data: 32'h33};
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_lsu_req", lsu_req, 36'h0);
        chk("arst_owner", owner, 0);
        step();
        rst = 1'b0;
        lock_grant(1);
`ifdef FALAFEL_ARB_STATS_EN
        chk("stats_port1", grant_cnt[1], 16'd1);
`endif
        owner_txn(1, UNLOCK);
        clear_inputs();

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < N; p++) begin
                core_req[p].val         = ($urandom_range(0, 2) != 0);
                core_req[p].lsu_op      = ($urandom_range(0, 9) < 4) ? LOCK : req_lsu_op_e'($urandom_range(1, 4));
                core_req[p].header_data = $urandom;
            end
            lsu_ready           = ($urandom_range(0, 3) != 0);
            lsu_rsp.val         = $urandom_range(0, 1) == 1;
            lsu_rsp.header_data = $urandom;
            step();
        end
        clear_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
